// File: rtl/ifm_dist_pkg.sv
// Shared types and configuration clamps for the IFM bank distributor.
// Bank and write-FSM state encodings live here so the top and bank modules agree.
package ifm_dist_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } wr_state_t;

    function automatic int clamp_range(input int req, input int max_val);
        if (req < 1)
            return 1;
        if (req > max_val)
            return max_val;
        return req;
    endfunction

    function automatic int clamp_num_banks(input int req, input int num_banks);
        return clamp_range(req, num_banks);
    endfunction

    function automatic int clamp_bank_len(input int req, input int depth);
        return clamp_range(req, depth);
    endfunction

endpackage

// File: rtl/ifm_bank_buffer.sv
// One IFM line-buffer bank: simple dual-port RAM, fill/drain counters and
// EMPTY/FILLING/FULL tracking with a registered 1-cycle read port.
module ifm_bank_buffer
    import ifm_dist_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [LEN_W-1:0]  bank_len,
    input  logic              wr_en,
    input  logic              wr_last,
    input  logic [DATA_W-1:0] wr_data,
    output logic              close,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output bank_state_t       state
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LEN_W-1:0]  wr_cnt;
    logic [LEN_W-1:0]  rd_addr;
    logic [LEN_W-1:0]  stored_len;
    logic              rd_fire;

    // Reads are only honoured once the bank has been released as a whole.
    assign rd_fire = rd_en && (state == FULL);
    assign close   = wr_en && (wr_last || ((wr_cnt + LEN_W'(1)) == bank_len));

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_cnt[ADDR_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            wr_cnt     <= '0;
            rd_addr    <= '0;
            stored_len <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else if (clear) begin
            state      <= EMPTY;
            wr_cnt     <= '0;
            rd_addr    <= '0;
            stored_len <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= mem[rd_addr[ADDR_W-1:0]];
                if (rd_addr == (stored_len - LEN_W'(1))) begin
                    state   <= EMPTY;
                    rd_addr <= '0;
                end else begin
                    rd_addr <= rd_addr + LEN_W'(1);
                end
            end
            if (wr_en) begin
                if (close) begin
                    state      <= FULL;
                    stored_len <= wr_cnt + LEN_W'(1);
                    wr_cnt     <= '0;
                end else begin
                    state  <= FILLING;
                    wr_cnt <= wr_cnt + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ifm_bank_distributor.sv
// Round-robin distributor of the RDMA2 IFM stream into NUM_BANKS line buffers,
// with ready-based back-pressure when the stream wraps onto an undrained bank.
module ifm_bank_distributor
    import ifm_dist_pkg::*;
#(
    parameter int NUM_BANKS = 12,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 512,
    parameter int LEN_W     = $clog2(DEPTH + 1),
    parameter int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic [BANK_W:0]             cfg_num_banks,
    input  logic [LEN_W-1:0]            cfg_bank_len,
    input  logic                        s_valid,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_last,
    output logic                        s_ready,
    input  logic [NUM_BANKS-1:0]        rd_en,
    output logic [NUM_BANKS*DATA_W-1:0] rd_data,
    output logic [NUM_BANKS-1:0]        rd_valid,
    output logic [NUM_BANKS-1:0]        bank_full,
    output logic [BANK_W-1:0]           wr_bank,
    output logic                        busy
);

    localparam int NB_W = BANK_W + 1;

    wr_state_t        state;
    wr_state_t        state_nxt;
    logic [NB_W-1:0]  eff_num_banks;
    logic [LEN_W-1:0] eff_len;
    logic [NB_W-1:0]  bank_inc;
    logic [BANK_W-1:0] nxt_bank;
    bank_state_t      bank_st [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_close;
    logic             hs;
    logic             close_any;

    // A word offered in the same cycle as cfg_start belongs to the aborted layer.
    assign hs        = s_valid && s_ready && !cfg_start;
    assign close_any = |bank_close;
    assign bank_inc  = {1'b0, wr_bank} + NB_W'(1);
    assign nxt_bank  = (bank_inc >= eff_num_banks) ? '0 : bank_inc[BANK_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank       <= '0;
            eff_num_banks <= '0;
            eff_len       <= '0;
        end else if (cfg_start) begin
            wr_bank       <= '0;
            eff_num_banks <= NB_W'(clamp_num_banks(int'(cfg_num_banks), NUM_BANKS));
            eff_len       <= LEN_W'(clamp_bank_len(int'(cfg_bank_len), DEPTH));
        end else if (close_any) begin
            wr_bank <= nxt_bank;
        end
    end

    // With a single active bank the next bank is the one just closed, so it is never EMPTY.
    always_comb begin
        state_nxt = state;
        if (cfg_start) begin
            state_nxt = WRITE;
        end else begin
            unique case (state)
                IDLE: state_nxt = IDLE;
                WRITE: begin
                    if (close_any) begin
                        if (s_last)
                            state_nxt = IDLE;
                        else if ((nxt_bank == wr_bank) || (bank_st[nxt_bank] != EMPTY))
                            state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (bank_st[wr_bank] == EMPTY)
                        state_nxt = WRITE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        s_ready = (state == WRITE) && (bank_st[wr_bank] != FULL);
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        ifm_bank_buffer #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .LEN_W  (LEN_W)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .clear    (cfg_start),
            .bank_len (eff_len),
            .wr_en    (hs && (wr_bank == BANK_W'(i))),
            .wr_last  (s_last),
            .wr_data  (s_data),
            .close    (bank_close[i]),
            .rd_en    (rd_en[i]),
            .rd_data  (rd_data[i*DATA_W +: DATA_W]),
            .rd_valid (rd_valid[i]),
            .state    (bank_st[i])
        );
        assign bank_full[i] = (bank_st[i] == FULL);
    end

endmodule

// File: doc/ifm_bank_distributor.md
# ifm_bank_distributor

Parametrised input-feature-map bank distributor for the RDMA2 read stream. It writes the incoming 64-bit words round-robin into NUM_BANKS independent line buffers. Each bank holds a programmable number of words and is released to the PE array as a full bank. The PE array drains banks independently. The stream is back-pressured with a ready signal instead of a global full flag, and a layer can end on a partially filled bank.

## Interface
Parameters:
- NUM_BANKS, 12, number of IFM banks.
- DATA_W, 64, word width.
- DEPTH, 512, words per bank.
- LEN_W, $clog2(DEPTH+1), width of length/count fields.
- BANK_W, $clog2(NUM_BANKS), width of bank index.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_start  in  1  single-cycle pulse; latches cfg_*, clears all banks, write pointer to 0.
- cfg_num_banks  in  BANK_W+1  number of active banks.
- cfg_bank_len  in  LEN_W  words per bank.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_W  stream word.
- s_last  in  1  final word of the layer, qualified by s_valid.
- s_ready  out  1  distributor accepts the word this cycle.
- rd_en  in  NUM_BANKS  per-bank read strobe.
- rd_data  out  NUM_BANKS*DATA_W  per-bank read word; bank i occupies bits [i*DATA_W +: DATA_W].
- rd_valid  out  NUM_BANKS  rd_data slice valid.
- bank_full  out  NUM_BANKS  bank filled and readable.
- wr_bank  out  BANK_W  bank currently being written.
- busy  out  1  a layer is in progress.

## Operation
Configuration:
- Effective values are computed at cfg_start. cfg_num_banks of 0 is treated as 1; a value above NUM_BANKS is clamped to NUM_BANKS. cfg_bank_len of 0 is treated as 1; a value above DEPTH is clamped to DEPTH.

Write FSM, states IDLE, WRITE, WAIT:
- IDLE -> WRITE on cfg_start.
- In WRITE, a handshake (s_valid & s_ready) stores s_data at the bank write address and increments it.
- When a bank reaches its length, or on a handshake with s_last: that bank is closed, and wr_bank advances to (wr_bank+1) mod eff_num_banks.
- s_last -> IDLE. Otherwise, if the next bank is not EMPTY -> WAIT.
- WAIT -> WRITE when the target bank becomes EMPTY.
- cfg_start in any state aborts the layer: all banks go to EMPTY, counters clear, the FSM goes to WRITE.

Bank states, EMPTY, FILLING, FULL:
- EMPTY -> FILLING on the first write.
- FILLING -> FULL on close. The stored length is the number of words written, so an s_last close holds fewer words than cfg_bank_len.
- FULL -> EMPTY after the rd_en that reads the word at address stored_len-1.
- rd_en on a bank that is not FULL is ignored: no rd_valid, no address change.
- Read address resets to 0 when the bank goes EMPTY.

Outputs:
- s_ready = busy & (FSM==WRITE) & (target bank != FULL). It is decoded from registered state only and never depends on s_valid.
- busy = FSM != IDLE.
- Banks with index >= eff_num_banks stay EMPTY.

## Timing
- Reset value of every output is 0.
- bank_full asserts the cycle after the closing write.
- bank_full deasserts the cycle after the final rd_en.
- rd_data/rd_valid: 1-cycle latency after rd_en (registered BRAM read). rd_data holds its last value when rd_valid=0.
- Wrap to a FULL bank: s_ready stays low. It rises 2 cycles after that bank's final rd_en (one cycle for bank→EMPTY, one cycle for FSM WAIT→WRITE). No word is lost or duplicated.
- Close and final read on different banks in the same cycle: both take effect.
- A write and a read never target the same bank in one cycle.
- s_last on the word that also reaches cfg_bank_len: a single close, pointer advances once.

## Structure
- Package ifm_dist_pkg holds:
  - bank state enum (EMPTY/FILLING/FULL);
  - write FSM enum (IDLE/WRITE/WAIT);
  - clamp functions for num_banks and bank_len.
- Sub-module ifm_bank_buffer: one bank with a DEPTH×DATA_W simple dual-port RAM, write/read address counters, stored length, state register, and 1-cycle registered read. It is instantiated NUM_BANKS times with a generate loop.
- The top level contains only the write FSM, the pointer, and the ready/valid decode.

## Test plan
- Basic fill: NUM_BANKS=12, cfg 3 banks, len 4, stream 12 words 0..11 with no reads. Banks 0/1/2 full, holding 0-3/4-7/8-11. s_ready drops after word 11; FSM in WAIT on bank 0.
- Drain/wrap: continue the previous case by draining bank 0 with 4 consecutive rd_en. rd_valid follows one cycle later with data 0,1,2,3. s_ready rises 2 cycles after the 4th rd_en; word 12 lands in bank 0 at address 0.
- Partial close: len 8, send 5 words with s_last on the 5th. Bank 0 full with length 5; after the 5th read bank_full=0 and busy=0.
- Clamp: cfg_num_banks=0, len=0. Every word closes bank 0, and a drain is required between words. cfg_num_banks=15 is clamped to 12, so the pointer wraps 11→0.
- Read of non-full bank: rd_en on a FILLING bank produces no rd_valid, and a later drain still returns data from address 0.
- Abort/reset: cfg_start mid-stream with 2 banks full clears all bank_full next cycle and restarts at wr_bank=0. Async rst mid-stream drives all outputs to 0 immediately.
